// File: rtl/adc_snap_capture_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module : adc_snap_capture_ctrl_if
// Brief  : Control, ADC stream, BRAM write port and status bundle for the
//          snapshot capture controller.
// Rev    : 1.0  initial release
// =============================================================================
interface adc_snap_capture_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
);
    logic [31:0]           ctrl_in;
    logic [DATA_WIDTH-1:0] adc_data;
    logic                  adc_valid;
    logic                  ext_trig;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_data;
    logic                  bram_we;
    logic [31:0]           status_out;

    modport master (
        output ctrl_in, adc_data, adc_valid, ext_trig,
        input  bram_addr, bram_data, bram_we, status_out
    );

    modport slave (
        input  ctrl_in, adc_data, adc_valid, ext_trig,
        output bram_addr, bram_data, bram_we, status_out
    );
endinterface
`default_nettype wire

// File: rtl/adc_snap_capture_ctrl.sv
`default_nettype none
// =============================================================================
// Module : adc_snap_capture_ctrl
// Brief  : Arms on a control-register edge, waits for an immediate/external/
//          software trigger and writes a fixed-depth ADC burst into BRAM.
// Rev    : 1.0  initial release
// =============================================================================
module adc_snap_capture_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic              user_clk,
    input  wire logic              user_rst,
    adc_snap_capture_ctrl_if.slave bus
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // Edge-detected bits (arm, soft_trig) reset high so a level held through
    // reset is not mistaken for a fresh 0->1 transition on release.
    logic [3:0]            r_q1;
    logic [1:0]            r_q2;        // {soft_trig, arm}
    logic [CNT_W-1:0]      r_count, w_count_nxt;
    logic [11:0]           r_cap_cnt, w_cap_cnt_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_we_nxt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [31:0]           r_status;
    logic [15:0]           w_count_field;

    logic w_arm_pulse;
    logic w_soft_pulse;
    logic w_trig_sel;
    logic w_abort;
    logic w_unused_ctrl;

    assign w_arm_pulse   = r_q1[0] & ~r_q2[0];
    assign w_soft_pulse  = r_q1[2] & ~r_q2[1];
    assign w_trig_sel    = r_q1[1];
    assign w_abort       = r_q1[3];
    assign w_unused_ctrl = ^bus.ctrl_in[31:4];

    generate
        if (CNT_W >= 16) begin : g_count_trunc
            assign w_count_field = r_count[15:0];
        end else begin : g_count_zext
            assign w_count_field = {{(16-CNT_W){1'b0}}, r_count};
        end
    endgenerate

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_cap_cnt_nxt = r_cap_cnt;
        w_done_nxt    = r_done;
        w_we_nxt      = 1'b0;

        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b0;
        end else if (w_arm_pulse) begin
            w_state_nxt = ST_ARMED;
            w_count_nxt = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (!w_trig_sel || bus.ext_trig || w_soft_pulse) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.adc_valid) begin
                        w_we_nxt    = 1'b1;
                        w_count_nxt = r_count + CNT_ONE;
                        // Last address: the final write and DONE land on the same edge.
                        if (r_count == LAST_ADDR) begin
                            w_state_nxt   = ST_DONE;
                            w_done_nxt    = 1'b1;
                            w_cap_cnt_nxt = r_cap_cnt + 12'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_q1      <= 4'b0101;
            r_q2      <= 2'b11;
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_cap_cnt <= '0;
            r_done    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_status  <= '0;
        end else begin
            r_q1      <= bus.ctrl_in[3:0];
            r_q2      <= {r_q1[2], r_q1[0]};
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_cap_cnt <= w_cap_cnt_nxt;
            r_done    <= w_done_nxt;
            r_we      <= w_we_nxt;
            if (w_we_nxt) begin
                r_addr <= r_count[ADDR_WIDTH-1:0];
                r_data <= bus.adc_data;
            end
            r_status  <= {r_done, (r_state == ST_CAPTURE), (r_state == ST_ARMED),
                          1'b0, r_cap_cnt, w_count_field};
        end
    end

    assign bus.bram_we    = r_we;
    assign bus.bram_addr  = r_addr;
    assign bus.bram_data  = r_data;
    assign bus.status_out = r_status;

endmodule
`default_nettype wire

// File: tb/tb_adc_snap_capture_ctrl.sv
`default_nettype none
// =============================================================================
// Module : tb_adc_snap_capture_ctrl
// Brief  : Directed bench for the snapshot capture controller (depth 16 main
//          instance, depth 4 instance for the capture counter wrap).
// Rev    : 1.0  initial release
// =============================================================================
module tb_adc_snap_capture_ctrl;

    localparam logic [63:0] DBASE = 64'hCAFE_0000_0000_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    adc_snap_capture_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) bus ();
    adc_snap_capture_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(2)) bus2 ();

    adc_snap_capture_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(4)) dut (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (bus)
    );

    adc_snap_capture_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut2 (
        .user_clk (clk),
        .user_rst (rst),
        .bus      (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ctrl_in = '0;  bus.adc_valid = 1'b0;  bus.adc_data = '0;  bus.ext_trig = 1'b0;
        bus2.ctrl_in = '0; bus2.adc_valid = 1'b0; bus2.adc_data = '0; bus2.ext_trig = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ctrl_in = 32'h1; bus.adc_valid = 1'b1; bus.adc_data = DBASE; bus.ext_trig = 1'b0;
        bus2.ctrl_in = '0; bus2.adc_valid = 1'b0; bus2.adc_data = '0; bus2.ext_trig = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            total++; if (bus.bram_we !== 1'b0) begin bad++; $display("FAIL rst_we n=%0d got=%b want=0", n, bus.bram_we); end
            total++; if (bus.status_out !== 32'h0) begin bad++; $display("FAIL rst_status n=%0d got=%h want=00000000", n, bus.status_out); end
        end
        total++; if (bus.bram_addr !== 4'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.bram_addr); end
        total++; if (bus.bram_data !== 64'h0) begin bad++; $display("FAIL rst_data got=%h want=0", bus.bram_data); end
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            total++; if (bus.status_out !== 32'h0) begin bad++; $display("FAIL held_arm n=%0d got=%h want=00000000", n, bus.status_out); end
        end
        bus.ctrl_in = 32'h0;
        tick();
        bus.ctrl_in = 32'h3;
        tick(); tick(); tick();
        total++; if (bus.status_out !== 32'h2000_0000) begin bad++; $display("FAIL rearm_after_rst got=%h want=20000000", bus.status_out); end
        do_reset();
    endtask

    task automatic test_immediate();
        logic exp_we;
        do_reset();
        for (int n = 1; n <= 21; n++) begin
            bus.ctrl_in = 32'h1; bus.adc_valid = 1'b1; bus.adc_data = DBASE | 64'(n);
            tick();
            exp_we = (n >= 4 && n <= 19);
            total++; if (bus.bram_we !== exp_we) begin bad++; $display("FAIL imm_we n=%0d got=%b want=%b", n, bus.bram_we, exp_we); end
            if (exp_we) begin
                total++; if (bus.bram_addr !== 4'(n - 4)) begin bad++; $display("FAIL imm_addr n=%0d got=%h want=%h", n, bus.bram_addr, 4'(n - 4)); end
                total++; if (bus.bram_data !== (DBASE | 64'(n))) begin bad++; $display("FAIL imm_data n=%0d got=%h want=%h", n, bus.bram_data, DBASE | 64'(n)); end
            end
            if (n == 4) begin
                total++; if (bus.status_out !== 32'h4000_0000) begin bad++; $display("FAIL imm_status_cap got=%h want=40000000", bus.status_out); end
            end
            if (n >= 20) begin
                total++; if (bus.status_out !== 32'h8001_0010) begin bad++; $display("FAIL imm_status_done n=%0d got=%h want=80010010", n, bus.status_out); end
            end
        end
    endtask

    task automatic test_gapped();
        logic exp_we;
        do_reset();
        for (int n = 1; n <= 36; n++) begin
            bus.ctrl_in = 32'h1; bus.adc_valid = (n % 2 == 0); bus.adc_data = DBASE | 64'(n);
            tick();
            exp_we = (n % 2 == 0) && n >= 4 && n <= 34;
            total++; if (bus.bram_we !== exp_we) begin bad++; $display("FAIL gap_we n=%0d got=%b want=%b", n, bus.bram_we, exp_we); end
            if (exp_we) begin
                total++; if (bus.bram_addr !== 4'((n - 4) / 2)) begin bad++; $display("FAIL gap_addr n=%0d got=%h want=%h", n, bus.bram_addr, 4'((n - 4) / 2)); end
                total++; if (bus.bram_data !== (DBASE | 64'(n))) begin bad++; $display("FAIL gap_data n=%0d got=%h want=%h", n, bus.bram_data, DBASE | 64'(n)); end
            end
            if (n == 34) begin
                total++; if (bus.status_out !== 32'h4000_000F) begin bad++; $display("FAIL gap_status_mid got=%h want=4000000f", bus.status_out); end
            end
            if (n >= 35) begin
                total++; if (bus.status_out !== 32'h8001_0010) begin bad++; $display("FAIL gap_status_done n=%0d got=%h want=80010010", n, bus.status_out); end
            end
        end
    endtask

    task automatic test_ext_trig();
        logic exp_we;
        do_reset();
        for (int n = 1; n <= 42; n++) begin
            bus.ctrl_in = (n == 1) ? 32'h2 : 32'h3;
            bus.ext_trig = (n == 25);
            bus.adc_valid = 1'b1; bus.adc_data = DBASE | 64'(n);
            tick();
            exp_we = (n >= 26 && n <= 41);
            total++; if (bus.bram_we !== exp_we) begin bad++; $display("FAIL ext_we n=%0d got=%b want=%b", n, bus.bram_we, exp_we); end
            if (exp_we) begin
                total++; if (bus.bram_addr !== 4'(n - 26)) begin bad++; $display("FAIL ext_addr n=%0d got=%h want=%h", n, bus.bram_addr, 4'(n - 26)); end
                total++; if (bus.bram_data !== (DBASE | 64'(n))) begin bad++; $display("FAIL ext_data n=%0d got=%h want=%h", n, bus.bram_data, DBASE | 64'(n)); end
            end
            if (n >= 4 && n <= 25) begin
                total++; if (bus.status_out !== 32'h2000_0000) begin bad++; $display("FAIL ext_wait_status n=%0d got=%h want=20000000", n, bus.status_out); end
            end
            if (n == 42) begin
                total++; if (bus.status_out !== 32'h8001_0010) begin bad++; $display("FAIL ext_status_done got=%h want=80010010", bus.status_out); end
            end
        end
    endtask

    task automatic test_abort_rearm();
        logic exp_we;
        do_reset();
        for (int n = 1; n <= 34; n++) begin
            if (n <= 7)       bus.ctrl_in = 32'h1;
            else if (n <= 12) bus.ctrl_in = 32'h9;
            else if (n <= 14) bus.ctrl_in = 32'h0;
            else              bus.ctrl_in = 32'h1;
            bus.adc_valid = 1'b1; bus.adc_data = DBASE | 64'(n);
            tick();
            exp_we = (n >= 4 && n <= 8) || (n >= 18 && n <= 33);
            total++; if (bus.bram_we !== exp_we) begin bad++; $display("FAIL abt_we n=%0d got=%b want=%b", n, bus.bram_we, exp_we); end
            if (exp_we) begin
                total++; if (bus.bram_addr !== ((n <= 8) ? 4'(n - 4) : 4'(n - 18))) begin bad++; $display("FAIL abt_addr n=%0d got=%h", n, bus.bram_addr); end
            end
            if (n == 11 || n == 12) begin
                total++; if (bus.status_out !== 32'h0000_0005) begin bad++; $display("FAIL abt_status n=%0d got=%h want=00000005", n, bus.status_out); end
            end
            if (n == 17) begin
                total++; if (bus.status_out !== 32'h2000_0000) begin bad++; $display("FAIL abt_rearm_status got=%h want=20000000", bus.status_out); end
            end
            if (n == 34) begin
                total++; if (bus.status_out !== 32'h8001_0010) begin bad++; $display("FAIL abt_done_status got=%h want=80010010", bus.status_out); end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic exp_we;
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            if (n <= 4)       bus.ctrl_in = 32'h9;
            else if (n <= 6)  bus.ctrl_in = 32'h0;
            else if (n <= 11) bus.ctrl_in = 32'h1;
            else if (n == 12) bus.ctrl_in = 32'h0;
            else              bus.ctrl_in = 32'h1;
            bus.adc_valid = 1'b1; bus.adc_data = DBASE | 64'(n);
            tick();
            exp_we = (n >= 10 && n <= 13) || (n == 16);
            total++; if (bus.bram_we !== exp_we) begin bad++; $display("FAIL sim_we n=%0d got=%b want=%b", n, bus.bram_we, exp_we); end
            if (exp_we) begin
                total++; if (bus.bram_addr !== ((n <= 13) ? 4'(n - 10) : 4'(n - 16))) begin bad++; $display("FAIL sim_addr n=%0d got=%h", n, bus.bram_addr); end
            end
            if (n == 3 || n == 4) begin
                total++; if (bus.status_out !== 32'h0) begin bad++; $display("FAIL sim_abort_wins n=%0d got=%h want=00000000", n, bus.status_out); end
            end
            if (n == 9 || n == 15) begin
                total++; if (bus.status_out !== 32'h2000_0000) begin bad++; $display("FAIL sim_armed n=%0d got=%h want=20000000", n, bus.status_out); end
            end
            if (n == 14) begin
                total++; if (bus.status_out !== 32'h4000_0004) begin bad++; $display("FAIL sim_cap_status got=%h want=40000004", bus.status_out); end
            end
        end
    endtask

    task automatic test_cap_wrap();
        logic [31:0] exp_st;
        do_reset();
        for (int k = 1; k <= 4097; k++) begin
            for (int j = 1; j <= 8; j++) begin
                bus2.ctrl_in = (j <= 7) ? 32'h1 : 32'h0;
                bus2.adc_valid = 1'b1; bus2.adc_data = 8'h5A;
                tick();
            end
            if (k == 1 || k == 4095 || k == 4096 || k == 4097) begin
                exp_st = 32'h8000_0004 | (32'(k % 4096) << 16);
                total++; if (bus2.status_out !== exp_st) begin bad++; $display("FAIL wrap_status k=%0d got=%h want=%h", k, bus2.status_out, exp_st); end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_immediate();
        test_gapped();
        test_ext_trig();
        test_abort_rearm();
        test_simultaneous();
        test_cap_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_snap_capture_ctrl.md
# adc_snap_capture_ctrl

Capture controller for the ADC-input calibration snapshot subsystem. It records a fixed-depth burst of ADC samples into the snapshot BRAM after a software arm and an immediate, external or software trigger. It also produces the 32-bit status word that the downstream simulink2ppc status register (`user_data_in`) exposes to the PPC. It sits between the ppc2simulink control register, the ADC sample stream and the snapshot BRAM write port.

## Interface
Parameters:
- `DATA_WIDTH`, 64, ADC sample word width written to BRAM.
- `ADDR_WIDTH`, 10, BRAM address width. Depth is 2^ADDR_WIDTH. Legal range is 2..16.

Ports:
- `user_clk`, in, 1: single clock for the whole block.
- `user_rst`, in, 1: synchronous, active-high reset.
- `ctrl_in`, in, 32: control word from the ppc2simulink register.
  - bit0 arm: acts on its rising edge.
  - bit1 trig_sel: 0 = immediate, 1 = wait for a trigger.
  - bit2 soft_trig: acts on its rising edge.
  - bit3 abort: acts on its level.
- `adc_data`, in, DATA_WIDTH: ADC sample.
- `adc_valid`, in, 1: `adc_data` is valid this cycle.
- `ext_trig`, in, 1: external trigger, level-sampled.
- `bram_addr`, out, ADDR_WIDTH: snapshot BRAM write address.
- `bram_data`, out, DATA_WIDTH: snapshot BRAM write data.
- `bram_we`, out, 1: snapshot BRAM write enable.
- `status_out`, out, 32: status word, drives `user_data_in` of the status register.

## Operation
- `ctrl_in` is registered twice (`q1`, `q2`).
  - arm_pulse = q1[0] & ~q2[0].
  - soft_pulse = q1[2] & ~q2[2].
  - trig_sel and abort are taken from q1.
- States:
  - IDLE (reset state).
  - ARMED.
  - CAPTURE.
  - DONE.
- Transitions, in priority order:
  - abort=1 → IDLE from any state. Count is retained, done is cleared. Abort beats a simultaneous arm_pulse.
  - arm_pulse → ARMED from any state. Count is cleared to 0, done is cleared.
  - ARMED → CAPTURE:
    - next cycle, if trig_sel=0;
    - otherwise on the first cycle with ext_trig=1 or soft_pulse=1.
  - CAPTURE: on each cycle with adc_valid=1:
    - write adc_data at address = count;
    - count increments.
    - When the write at address 2^ADDR_WIDTH-1 is issued, the state goes to DONE and capture_cnt increments (wraps mod 4096).
  - DONE: held until arm_pulse or abort.
- Samples with adc_valid=0 are skipped. There are no gaps in the address sequence.
- count is ADDR_WIDTH+1 bits and ends at exactly 2^ADDR_WIDTH. It never exceeds that value.
- Triggers arriving in IDLE, CAPTURE or DONE are ignored. No triggers are queued.
- A held arm bit does not re-arm. Only a 0→1 transition re-arms.
- status_out fields:
  - [31] done.
  - [30] capturing (state==CAPTURE).
  - [29] armed (state==ARMED).
  - [28] 0.
  - [27:16] capture_cnt.
  - [15:0] count, zero-extended.

## Timing
- Reset values:
  - bram_we=0, bram_addr=0, bram_data=0.
  - status_out=0.
  - state=IDLE, count=0, capture_cnt=0.
- If ctrl_in bit0 is first sampled high at edge N, then arm_pulse is high in cycle N+1 and state=ARMED after edge N+1.
- With trig_sel=0, state=CAPTURE after edge N+2.
- With trig_sel=1, if ext_trig is sampled high at edge M in ARMED, state=CAPTURE after edge M.
- Write path is registered, with 1-cycle latency. If adc_data/adc_valid are sampled at edge K in CAPTURE, then bram_we/addr/data are valid after edge K, i.e. during cycle K+1.
- bram_we is 1 for exactly one cycle per accepted sample.
- The last write and the DONE state appear together after the same edge.
- status_out is registered from state, count and capture_cnt. It lags them by one cycle.
- Reset asserted mid-capture: outputs are at reset values after that edge, and there is no further write.

## Test plan
- Reset:
  - Stimulus: hold user_rst 3 cycles with adc_valid=1 and ctrl_in=0x1.
  - Required response: bram_we=0 and status_out=0x00000000 throughout. No ARMED state until arm toggles 0→1 after reset.
- Immediate capture, ADDR_WIDTH=4:
  - Stimulus: arm with trig_sel=0, continuous adc_valid, adc_data=sample index.
  - Required response: 16 writes at addresses 0..15 with data matching. Final status_out=0x80010010.
- Gapped valid:
  - Stimulus: adc_valid alternating 1/0 during capture.
  - Required response: addresses stay contiguous 0..15. Capture takes 32 cycles. bram_we is never high on a cycle that follows a sampled adc_valid=0.
- External trigger:
  - Stimulus: trig_sel=1, then arm; wait 20 cycles with ext_trig=0; then pulse ext_trig for 1 cycle.
  - Required response: status_out=0x20000000 while waiting. First write one cycle after the trigger edge.
- Abort and re-arm:
  - Stimulus: abort after 5 writes; then clear abort; then arm again.
  - Required response: status_out=0x00000005 after the abort. After the re-arm, count restarts at 0 and a full capture completes.
- Simultaneous events:
  - Stimulus: arm rising edge in the same cycle abort=1.
  - Required response: IDLE is the result.
  - Stimulus: arm during CAPTURE.
  - Required response: count returns to 0 and the state is ARMED.
  - Stimulus: 4097 completed captures.
  - Required response: capture_cnt wraps to 1.
